// File: rtl/i3c_ram_1p_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i3c_ram_1p_fifo_ctrl                                          |
// | Brief    : valid/ready FIFO on one single-port SRAM; writes and prefetch |
// |            reads share the port, a small buffer hides the read latency.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i3c_ram_1p_fifo_ctrl #(
    parameter  int DEPTH            = 64,
    parameter  int WIDTH            = 32,
    parameter  int RAM_READ_LATENCY = 1,
    localparam int c_pf_depth       = RAM_READ_LATENCY + 1,
    localparam int c_cap            = DEPTH + c_pf_depth,
    localparam int c_aw             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int c_cw             = $clog2(c_cap + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [c_cw-1:0]  count_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [c_aw-1:0]  ram_addr_o,
    output logic [WIDTH-1:0] ram_wdata_o,
    output logic [WIDTH-1:0] ram_wmask_o,
    input  logic [WIDTH-1:0] ram_rdata_i,
    input  logic             ram_rvalid_i,
    input  logic [1:0]       ram_rerror_i,
    output logic             err_uncorr_o,
    output logic             err_proto_o
);
    localparam int c_pw = $clog2(c_pf_depth);

    logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0]  r_ram_cnt, r_inflight, r_buf_cnt, r_discard_cnt;
    logic [c_pw-1:0]  r_buf_head, r_buf_tail;
    logic             r_rr_wr;
    logic             r_err_uncorr, r_err_proto;
    logic [WIDTH-1:0] r_buf [c_pf_depth];

    logic [c_cw-1:0]  w_count;
    logic             w_push_ready, w_wr_elig, w_rd_elig, w_wr_go, w_rd_go, w_pop;
    logic             w_drop, w_deliver, w_proto, w_resp_live, w_buf_push;
    logic             w_unused_rerror;

    assign w_count      = r_ram_cnt + r_inflight + r_buf_cnt;
    assign w_push_ready = w_count < c_cw'(c_cap);
    assign w_wr_elig    = push_valid_i && w_push_ready && (r_ram_cnt < c_cw'(DEPTH));
    // Read credit covers in-flight reads plus buffered words, so the buffer cannot overflow.
    assign w_rd_elig    = (r_ram_cnt != '0) && ((r_inflight + r_buf_cnt) < c_cw'(c_pf_depth));
    assign w_wr_go      = !clear_i && w_wr_elig && (!w_rd_elig || !r_rr_wr);
    assign w_rd_go      = !clear_i && w_rd_elig && (!w_wr_elig || r_rr_wr);
    assign w_pop        = pop_valid_o && pop_ready_i && !clear_i;

    assign w_drop       = ram_rvalid_i && (r_discard_cnt != '0);
    assign w_deliver    = ram_rvalid_i && (r_discard_cnt == '0) && (r_inflight != '0);
    assign w_proto      = ram_rvalid_i && (r_discard_cnt == '0) && (r_inflight == '0);
    assign w_resp_live  = w_drop || w_deliver;
    assign w_buf_push   = w_deliver && !clear_i;
    assign w_unused_rerror = ram_rerror_i[0];

    assign push_ready_o = w_push_ready;
    assign pop_valid_o  = r_buf_cnt != '0;
    assign pop_data_o   = pop_valid_o ? r_buf[r_buf_head] : '0;
    assign count_o      = w_count;
    assign ram_req_o    = w_wr_go || w_rd_go;
    assign ram_write_o  = w_wr_go;
    assign ram_addr_o   = w_wr_go ? r_wr_ptr : r_rd_ptr;
    assign ram_wdata_o  = push_data_i;
    assign ram_wmask_o  = '1;
    assign err_uncorr_o = r_err_uncorr;
    assign err_proto_o  = r_err_proto;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_cnt     <= '0;
            r_inflight    <= '0;
            r_buf_cnt     <= '0;
            r_discard_cnt <= '0;
            r_buf_head    <= '0;
            r_buf_tail    <= '0;
            r_rr_wr       <= 1'b0;
            r_err_uncorr  <= 1'b0;
            r_err_proto   <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_cnt     <= '0;
            r_inflight    <= '0;
            r_buf_cnt     <= '0;
            r_buf_head    <= '0;
            r_buf_tail    <= '0;
            r_rr_wr       <= 1'b0;
            // Reads still in the RAM pipeline must be swallowed; one may be answered this cycle.
            r_discard_cnt <= r_discard_cnt + r_inflight - c_cw'(w_resp_live);
            if (w_proto) begin
                r_err_proto <= 1'b1;
            end
        end else begin
            if (w_wr_go) begin
                r_wr_ptr <= (r_wr_ptr == c_aw'(DEPTH - 1)) ? '0 : r_wr_ptr + c_aw'(1);
            end
            if (w_rd_go) begin
                r_rd_ptr <= (r_rd_ptr == c_aw'(DEPTH - 1)) ? '0 : r_rd_ptr + c_aw'(1);
            end
            r_ram_cnt     <= r_ram_cnt + c_cw'(w_wr_go) - c_cw'(w_rd_go);
            r_inflight    <= r_inflight + c_cw'(w_rd_go) - c_cw'(w_deliver);
            r_discard_cnt <= r_discard_cnt - c_cw'(w_drop);
            r_buf_cnt     <= r_buf_cnt + c_cw'(w_buf_push) - c_cw'(w_pop);
            if (w_buf_push) begin
                r_buf_tail <= (r_buf_tail == c_pw'(c_pf_depth - 1)) ? '0 : r_buf_tail + c_pw'(1);
            end
            if (w_pop) begin
                r_buf_head <= (r_buf_head == c_pw'(c_pf_depth - 1)) ? '0 : r_buf_head + c_pw'(1);
            end
            if (w_wr_elig && w_rd_elig) begin
                r_rr_wr <= w_wr_go;
            end
            if (w_deliver && ram_rerror_i[1]) begin
                r_err_uncorr <= 1'b1;
            end
            if (w_proto) begin
                r_err_proto <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_buf_push) begin
            r_buf[r_buf_tail] <= ram_rdata_i;
        end
    end

endmodule
`default_nettype wire
